// File: rtl/dphy_tx_lane_sequencer_if.sv
// ---------------------------------------------------------------------------
// dphy_tx_lane_sequencer_if : request/payload and PHY-side signals of the
// D-PHY TX lane sequencer.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dphy_tx_lane_sequencer_if;
  logic       hs_clk_en;
  logic       hs_data_en;
  logic [7:0] data_in0;
  logic [7:0] data_in1;
  logic [7:0] data_in2;
  logic [7:0] data_in3;
  logic       hs_ready;
  logic [7:0] hs_data0;
  logic [7:0] hs_data1;
  logic [7:0] hs_data2;
  logic [7:0] hs_data3;
  logic       hs_data_oe;
  logic [1:0] lp_data0;
  logic [1:0] lp_data1;
  logic [1:0] lp_data2;
  logic [1:0] lp_data3;
  logic [7:0] hs_clk_byte;
  logic       hs_clk_oe;
  logic [1:0] lp_clk;

  modport master (
    output hs_clk_en, hs_data_en, data_in0, data_in1, data_in2, data_in3,
    input  hs_ready, hs_data0, hs_data1, hs_data2, hs_data3, hs_data_oe,
    input  lp_data0, lp_data1, lp_data2, lp_data3, hs_clk_byte, hs_clk_oe, lp_clk
  );

  modport slave (
    input  hs_clk_en, hs_data_en, data_in0, data_in1, data_in2, data_in3,
    output hs_ready, hs_data0, hs_data1, hs_data2, hs_data3, hs_data_oe,
    output lp_data0, lp_data1, lp_data2, lp_data3, hs_clk_byte, hs_clk_oe, lp_clk
  );
endinterface

`default_nettype wire

// File: rtl/dphy_tx_lane_sequencer.sv
// ---------------------------------------------------------------------------
// dphy_tx_lane_sequencer : byte-clock MIPI D-PHY TX LP/HS entry/exit sequencer
// for one clock lane and up to four lockstep data lanes.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dphy_tx_lane_sequencer #(
  parameter int LANES       = 4,
  parameter int LPX         = 2,
  parameter int HS_PREPARE  = 2,
  parameter int HS_ZERO     = 6,
  parameter int HS_TRAIL    = 4,
  parameter int CLK_PREPARE = 2,
  parameter int CLK_ZERO    = 16,
  parameter int CLK_PRE     = 2,
  parameter int CLK_POST    = 4,
  parameter int CLK_TRAIL   = 3
) (
  input  logic                      clk_byte,
  input  logic                      reset,
  dphy_tx_lane_sequencer_if.slave   bus
);

  localparam int CW = 8;

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_LPX   = 3'd1;
  localparam logic [2:0] C_PREP  = 3'd2;
  localparam logic [2:0] C_ZERO  = 3'd3;
  localparam logic [2:0] C_HS    = 3'd4;
  localparam logic [2:0] C_POST  = 3'd5;
  localparam logic [2:0] C_TRAIL = 3'd6;

  localparam logic [2:0] D_IDLE  = 3'd0;
  localparam logic [2:0] D_LPX   = 3'd1;
  localparam logic [2:0] D_PREP  = 3'd2;
  localparam logic [2:0] D_ZERO  = 3'd3;
  localparam logic [2:0] D_HS    = 3'd4;
  localparam logic [2:0] D_TRAIL = 3'd5;

  logic [2:0]      c_state_q, c_state_d, d_state_q, d_state_d;
  logic [CW-1:0]   c_cnt_q, c_cnt_d, d_cnt_q, d_cnt_d;
  logic [1:0]      lp_clk_q, lp_clk_d, lp_data_q, lp_data_d;
  logic            hs_clk_oe_q, hs_clk_oe_d, hs_data_oe_q, hs_data_oe_d;
  logic            hs_ready_q, hs_ready_d;
  logic [7:0]      hs_clk_byte_q, hs_clk_byte_d;
  logic [3:0][7:0] hs_data_q, hs_data_d;
  logic [3:0][7:0] w_data_in;
  logic [3:0][1:0] w_lp_lane;

  assign w_data_in = {bus.data_in3, bus.data_in2, bus.data_in1, bus.data_in0};

  always_ff @(posedge clk_byte or posedge reset) begin
    if (reset) begin
      c_state_q     <= C_IDLE;
      d_state_q     <= D_IDLE;
      c_cnt_q       <= '0;
      d_cnt_q       <= '0;
      lp_clk_q      <= 2'b11;
      lp_data_q     <= 2'b11;
      hs_clk_oe_q   <= 1'b0;
      hs_data_oe_q  <= 1'b0;
      hs_ready_q    <= 1'b0;
      hs_clk_byte_q <= 8'h00;
      hs_data_q     <= '0;
    end else begin
      c_state_q     <= c_state_d;
      d_state_q     <= d_state_d;
      c_cnt_q       <= c_cnt_d;
      d_cnt_q       <= d_cnt_d;
      lp_clk_q      <= lp_clk_d;
      lp_data_q     <= lp_data_d;
      hs_clk_oe_q   <= hs_clk_oe_d;
      hs_data_oe_q  <= hs_data_oe_d;
      hs_ready_q    <= hs_ready_d;
      hs_clk_byte_q <= hs_clk_byte_d;
      hs_data_q     <= hs_data_d;
    end
  end

  // Clock lane may only leave HS when the data lanes are idle and not starting a burst this edge.
  always_comb begin
    c_state_d = c_state_q;
    case (c_state_q)
      C_IDLE:  if (bus.hs_clk_en) c_state_d = C_LPX;
      C_LPX:   if (c_cnt_q == CW'(LPX - 1)) c_state_d = C_PREP;
      C_PREP:  if (c_cnt_q == CW'(CLK_PREPARE - 1)) c_state_d = C_ZERO;
      C_ZERO:  if (c_cnt_q == CW'(CLK_ZERO - 1)) c_state_d = C_HS;
      C_HS:    if (!bus.hs_clk_en && d_state_q == D_IDLE && d_state_d == D_IDLE) c_state_d = C_POST;
      C_POST:  if (c_cnt_q == CW'(CLK_POST - 1)) c_state_d = C_TRAIL;
      C_TRAIL: if (c_cnt_q == CW'(CLK_TRAIL - 1)) c_state_d = C_IDLE;
      default: c_state_d = C_IDLE;
    endcase
    if (c_state_d != c_state_q || c_state_q == C_IDLE) c_cnt_d = '0;
    else if (c_state_q == C_HS) c_cnt_d = (c_cnt_q < CW'(CLK_PRE)) ? c_cnt_q + CW'(1) : c_cnt_q;
    else c_cnt_d = c_cnt_q + CW'(1);
  end

  always_comb begin
    d_state_d = d_state_q;
    case (d_state_q)
      D_IDLE:  if (bus.hs_data_en && c_state_q == C_HS && c_cnt_q >= CW'(CLK_PRE)) d_state_d = D_LPX;
      D_LPX:   if (d_cnt_q == CW'(LPX - 1)) d_state_d = D_PREP;
      D_PREP:  if (d_cnt_q == CW'(HS_PREPARE - 1)) d_state_d = D_ZERO;
      D_ZERO:  if (d_cnt_q == CW'(HS_ZERO - 1)) d_state_d = bus.hs_data_en ? D_HS : D_TRAIL;
      D_HS:    if (!bus.hs_data_en) d_state_d = D_TRAIL;
      D_TRAIL: if (d_cnt_q == CW'(HS_TRAIL - 1)) d_state_d = D_IDLE;
      default: d_state_d = D_IDLE;
    endcase
    if (d_state_d != d_state_q || d_state_q == D_IDLE || d_state_q == D_HS) d_cnt_d = '0;
    else d_cnt_d = d_cnt_q + CW'(1);
  end

  always_comb begin
    lp_clk_d      = 2'b00;
    hs_clk_oe_d   = 1'b0;
    hs_clk_byte_d = 8'h00;
    case (c_state_d)
      C_IDLE:        lp_clk_d = 2'b11;
      C_LPX:         lp_clk_d = 2'b01;
      C_ZERO:        hs_clk_oe_d = 1'b1;
      C_HS, C_POST:  begin hs_clk_oe_d = 1'b1; hs_clk_byte_d = 8'h55; end
      C_TRAIL:       hs_clk_oe_d = 1'b1;
      default:       ;
    endcase
  end

  // Staying in D_HS implies hs_data_en was high, so the payload is captured; the trail byte
  // is latched from bit 7 of whatever byte each lane last carried.
  always_comb begin
    lp_data_d    = 2'b00;
    hs_data_oe_d = 1'b0;
    hs_ready_d   = 1'b0;
    hs_data_d    = '0;
    case (d_state_d)
      D_IDLE:  lp_data_d = 2'b11;
      D_LPX:   lp_data_d = 2'b01;
      D_ZERO:  hs_data_oe_d = 1'b1;
      D_HS: begin
        hs_data_oe_d = 1'b1;
        hs_ready_d   = 1'b1;
        for (int i = 0; i < 4; i++)
          hs_data_d[i] = (d_state_q == D_HS) ? w_data_in[i] : hs_data_q[i];
      end
      D_TRAIL: begin
        hs_data_oe_d = 1'b1;
        for (int i = 0; i < 4; i++)
          hs_data_d[i] = (d_state_q == D_TRAIL) ? hs_data_q[i] : {8{~hs_data_q[i][7]}};
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++)
      if (i >= LANES) hs_data_d[i] = 8'h00;
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    if (g < LANES) begin : g_active
      assign w_lp_lane[g] = lp_data_q;
    end else begin : g_idle
      assign w_lp_lane[g] = 2'b11;
    end
  end

  assign bus.hs_ready    = hs_ready_q;
  assign bus.hs_data0    = hs_data_q[0];
  assign bus.hs_data1    = hs_data_q[1];
  assign bus.hs_data2    = hs_data_q[2];
  assign bus.hs_data3    = hs_data_q[3];
  assign bus.hs_data_oe  = hs_data_oe_q;
  assign bus.lp_data0    = w_lp_lane[0];
  assign bus.lp_data1    = w_lp_lane[1];
  assign bus.lp_data2    = w_lp_lane[2];
  assign bus.lp_data3    = w_lp_lane[3];
  assign bus.hs_clk_byte = hs_clk_byte_q;
  assign bus.hs_clk_oe   = hs_clk_oe_q;
  assign bus.lp_clk      = lp_clk_q;

endmodule

`default_nettype wire

// File: tb/tb_dphy_tx_lane_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dphy_tx_lane_sequencer : directed vector bench for the D-PHY TX sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dphy_tx_lane_sequencer;

  logic clk_byte = 1'b0;
  logic reset    = 1'b1;
  always #5 clk_byte = ~clk_byte;

  dphy_tx_lane_sequencer_if bus();
  dphy_tx_lane_sequencer_if bus2();

  assign bus2.hs_clk_en  = bus.hs_clk_en;
  assign bus2.hs_data_en = bus.hs_data_en;
  assign bus2.data_in0   = bus.data_in0;
  assign bus2.data_in1   = bus.data_in1;
  assign bus2.data_in2   = bus.data_in2;
  assign bus2.data_in3   = bus.data_in3;

  dphy_tx_lane_sequencer u_dut (.clk_byte(clk_byte), .reset(reset), .bus(bus));
  dphy_tx_lane_sequencer #(.LANES(2)) u_dut2 (.clk_byte(clk_byte), .reset(reset), .bus(bus2));

  typedef struct packed {
    logic            ce;
    logic            de;
    logic [7:0]      din0;
    logic [1:0]      lpc;
    logic            coe;
    logic [7:0]      cb;
    logic [1:0]      lpd;
    logic            doe;
    logic            rdy;
    logic [3:0][7:0] db;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] din_k(input logic [7:0] b, input int k);
    logic [1:0] kk;
    kk = k[1:0];
    return b ^ {kk, 6'b0};
  endfunction

  function automatic logic [7:0] pay(input int id, input int j);
    if (id == 0) return (j == 0) ? 8'hB8 : 8'(j - 1);
    case (j)
      0:       return 8'h12;
      1:       return 8'h34;
      default: return 8'h80;
    endcase
  endfunction

  // Row n is checked after the n-th edge of a burst. Timing with default parameters:
  // clock LP-01 rows 0-1, LP-00 2-3, HS-zero 4-19, 0x55 from 20; data leaves LP-11 at row 23,
  // LP-01 23-24, LP-00 25-26, zero 27-32, ready from 33, payload rows 34..T-1 with T = 34+P.
  task automatic add_burst(input int id, input int p);
    int         t;
    logic [7:0] lb;
    t = 34 + p;
    for (int n = 0; n <= t + 12; n++) begin
      vec_t v;
      v      = '0;
      v.ce   = (n < t);
      v.de   = (n < t);
      v.din0 = (n >= 34 && n < t) ? pay(id, n - 34) : 8'h00;
      v.lpc  = (n < 2) ? 2'b01 : (n >= t + 12) ? 2'b11 : 2'b00;
      v.coe  = (n >= 4 && n < t + 12);
      v.cb   = (n >= 20 && n < t + 9) ? 8'h55 : 8'h00;
      v.lpd  = (n >= 23 && n < 25) ? 2'b01 : (n >= 25 && n < t + 4) ? 2'b00 : 2'b11;
      v.doe  = (n >= 27 && n < t + 4);
      v.rdy  = (n >= 33 && n < t);
      for (int k = 0; k < 4; k++) begin
        lb = din_k(pay(id, p - 1), k);
        if (n >= 34 && n < t)          v.db[k] = din_k(v.din0, k);
        else if (n >= t && n < t + 4)  v.db[k] = {8{~lb[7]}};
        else                           v.db[k] = 8'h00;
      end
      tbl.push_back(v);
    end
  endtask

  task automatic drive(input logic ce, input logic de, input logic [7:0] d0);
    bus.hs_clk_en  = ce;
    bus.hs_data_en = de;
    bus.data_in0   = d0;
    bus.data_in1   = din_k(d0, 1);
    bus.data_in2   = din_k(d0, 2);
    bus.data_in3   = din_k(d0, 3);
  endtask

  // Lanes beyond LANES on the two-lane instance must stay idle at all times.
  always @(negedge clk_byte) begin
    check("lanes2 lp_data2", bus2.lp_data2, 2'b11);
    check("lanes2 lp_data3", bus2.lp_data3, 2'b11);
    check("lanes2 hs_data2", bus2.hs_data2, 8'h00);
    check("lanes2 hs_data3", bus2.hs_data3, 8'h00);
  end

  initial begin
    int w;
    drive(1'b0, 1'b0, 8'h00);
    add_burst(0, 17);
    add_burst(1, 3);

    @(posedge clk_byte); #1;
    check("reset lp_clk", bus.lp_clk, 2'b11);
    check("reset hs_clk_oe", bus.hs_clk_oe, 1'b0);
    check("reset hs_clk_byte", bus.hs_clk_byte, 8'h00);
    check("reset lp_data0", bus.lp_data0, 2'b11);
    check("reset lp_data3", bus.lp_data3, 2'b11);
    check("reset hs_data_oe", bus.hs_data_oe, 1'b0);
    check("reset hs_ready", bus.hs_ready, 1'b0);
    check("reset hs_data0", bus.hs_data0, 8'h00);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].ce, tbl[i].de, tbl[i].din0);
      @(posedge clk_byte); #1;
      check($sformatf("row%0d lp_clk", i), bus.lp_clk, tbl[i].lpc);
      check($sformatf("row%0d hs_clk_oe", i), bus.hs_clk_oe, tbl[i].coe);
      check($sformatf("row%0d hs_clk_byte", i), bus.hs_clk_byte, tbl[i].cb);
      check($sformatf("row%0d lp_data0", i), bus.lp_data0, tbl[i].lpd);
      check($sformatf("row%0d lp_data3", i), bus.lp_data3, tbl[i].lpd);
      check($sformatf("row%0d hs_data_oe", i), bus.hs_data_oe, tbl[i].doe);
      check($sformatf("row%0d hs_ready", i), bus.hs_ready, tbl[i].rdy);
      check($sformatf("row%0d hs_data0", i), bus.hs_data0, tbl[i].db[0]);
      check($sformatf("row%0d hs_data1", i), bus.hs_data1, tbl[i].db[1]);
      check($sformatf("row%0d hs_data2", i), bus.hs_data2, tbl[i].db[2]);
      check($sformatf("row%0d hs_data3", i), bus.hs_data3, tbl[i].db[3]);
    end

    // Early drop: hs_data_en falls during LP-00, so zero is followed directly by a 0xFF trail.
    for (int n = 0; n <= 37; n++) begin
      drive(1'b1, (n < 26), 8'h00);
      @(posedge clk_byte); #1;
      check($sformatf("drop%0d hs_ready", n), bus.hs_ready, 1'b0);
      if (n >= 33 && n <= 36) begin
        check($sformatf("drop%0d hs_data0", n), bus.hs_data0, 8'hFF);
        check($sformatf("drop%0d hs_data3", n), bus.hs_data3, 8'hFF);
        check($sformatf("drop%0d hs_data_oe", n), bus.hs_data_oe, 1'b1);
      end
      if (n == 37) begin
        check("drop37 lp_data0", bus.lp_data0, 2'b11);
        check("drop37 hs_data_oe", bus.hs_data_oe, 1'b0);
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    w = 0;
    while (bus.lp_clk !== 2'b11 && w < 40) begin
      @(posedge clk_byte); #1;
      w++;
    end
    check("drop clock back to LP-11", bus.lp_clk, 2'b11);

    // Data request without the clock lane running: data lanes stay in LP-11.
    for (int n = 0; n < 6; n++) begin
      drive(1'b0, 1'b1, 8'hAA);
      @(posedge clk_byte); #1;
      check($sformatf("noclk%0d lp_data0", n), bus.lp_data0, 2'b11);
      check($sformatf("noclk%0d hs_data_oe", n), bus.hs_data_oe, 1'b0);
      check($sformatf("noclk%0d lp_clk", n), bus.lp_clk, 2'b11);
    end

    // Asynchronous reset in the middle of clock HS / data LP-00.
    drive(1'b1, 1'b1, 8'h00);
    repeat (26) @(posedge clk_byte);
    #2;
    check("pre-reset hs_clk_oe", bus.hs_clk_oe, 1'b1);
    check("pre-reset lp_data0", bus.lp_data0, 2'b00);
    reset = 1'b1;
    #1;
    check("midreset lp_clk", bus.lp_clk, 2'b11);
    check("midreset hs_clk_oe", bus.hs_clk_oe, 1'b0);
    check("midreset hs_clk_byte", bus.hs_clk_byte, 8'h00);
    check("midreset lp_data0", bus.lp_data0, 2'b11);
    check("midreset lp_data1", bus.lp_data1, 2'b11);
    check("midreset hs_data_oe", bus.hs_data_oe, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    @(posedge clk_byte); #1;
    reset = 1'b0;
    @(posedge clk_byte); #1;
    check("post-reset lp_clk", bus.lp_clk, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
